// File: rtl/alu_4b_ctrl.sv
// Sequencing controller and round-robin arbiter for the alu_4b datapath:
// grants one of two requesters, drives the ALU from registers, waits a settle cycle, captures the result.
module alu_4b_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [1:0]       op0,
    input  logic [1:0]       op1,
    input  logic [3:0]       a0,
    input  logic [3:0]       b0,
    input  logic [3:0]       a1,
    input  logic [3:0]       b1,
    input  logic             cin0,
    input  logic             cin1,
    output logic [3:0]       x,
    output logic [3:0]       y,
    output logic             z,
    output logic             p1,
    output logic             p2,
    input  logic [7:0]       m,
    input  logic [3:0]       e,
    input  logic             c,
    output logic [1:0]       gnt,
    output logic             done0,
    output logic             done1,
    output logic [7:0]       res,
    output logic             cout,
    output logic             err,
    output logic             busy,
    output logic [CNT_W-1:0] op_cnt
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DRIVE  = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0] state;
    logic       ptr;
    logic       owner;
    logic       sel;

    // Handshake: a requester raises req with stable op/a/b/cin and holds it until its done
    // pulse; operands are latched at grant, and req is ignored during the DONE cycle.
    always_comb begin
        sel = (req0 && req1) ? ptr : req1;
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            ptr    <= 1'b0;
            owner  <= 1'b0;
            x      <= 4'd0;
            y      <= 4'd0;
            z      <= 1'b0;
            p1     <= 1'b0;
            p2     <= 1'b0;
            gnt    <= 2'b00;
            done0  <= 1'b0;
            done1  <= 1'b0;
            res    <= 8'd0;
            cout   <= 1'b0;
            err    <= 1'b0;
            op_cnt <= '0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        owner    <= sel;
                        x        <= sel ? a1 : a0;
                        y        <= sel ? b1 : b0;
                        z        <= sel ? cin1 : cin0;
                        {p1, p2} <= sel ? op1 : op0;
                        gnt      <= sel ? 2'b10 : 2'b01;
                        state    <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    state <= ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    // Outputs are registered here so they are valid throughout the DONE cycle.
                    case ({p1, p2})
                        2'b10: begin
                            res  <= m;
                            cout <= 1'b0;
                            err  <= 1'b0;
                        end
                        2'b11: begin
                            res  <= {4'b0, e};
                            cout <= 1'b0;
                            err  <= c;
                        end
                        default: begin
                            res  <= {4'b0, e};
                            cout <= c;
                            err  <= 1'b0;
                        end
                    endcase
                    done0  <= ~owner;
                    done1  <= owner;
                    op_cnt <= op_cnt + CNT_ONE;
                    ptr    <= ~owner;
                    state  <= ST_DONE;
                end
                default: begin
                    gnt   <= 2'b00;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
